write_burst_ctrl: RTL

WRITE_BURST_CTRL -- requirements
Module: write_burst_ctrl

---
 rtl/write_burst_ctrl.sv | 118 +++++++++++
 1 files changed

// File: rtl/write_burst_ctrl.sv
// rtl/write_burst_ctrl.sv - write burst controller: 1/4-beat memory writes, linear or line-wrap addressing
// Optional beat parity checking is enabled by defining WR_PARITY_EN.
module write_burst_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [3:0]  cmd,
  input  logic [3:0]  local_address,
  input  logic [1:0]  mode,
  input  logic [31:0] data_in,
  input  logic        data_valid,
  input  logic        par_in,
  output logic        ready,
  output logic [3:0]  add_2_mem,
  output logic [31:0] data_2_mem,
  output logic        wr_en,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam logic [3:0] CMD_MEM_WRITE     = 4'b0111;
  localparam logic [3:0] CMD_MEM_WRITE_INV = 4'b1111;
  localparam logic [1:0] MODE_WRAP         = 2'b10;
  localparam logic [1:0] MODE_RESERVED     = 2'b11;

`ifdef WR_PARITY_EN
  localparam bit PARITY_CHECK = 1'b1;
`else
  localparam bit PARITY_CHECK = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, DATA, DONE} state_t;

  state_t      state;
  logic [3:0]  base_addr;
  logic [1:0]  burst_mode;
  logic        long_burst;
  logic [1:0]  beat_cnt;

  logic        cmd_ok;
  logic [3:0]  beat_addr;
  logic        last_beat;
  logic        parity_bad;
  logic        beat_ok;

  always_comb begin
    cmd_ok     = (cmd == CMD_MEM_WRITE || cmd == CMD_MEM_WRITE_INV) && (mode != MODE_RESERVED);
    beat_addr  = (burst_mode == MODE_WRAP) ? {base_addr[3:2], base_addr[1:0] + beat_cnt}
                                           : base_addr + {2'b00, beat_cnt};
    last_beat  = long_burst ? (beat_cnt == 2'd3) : 1'b1;
    parity_bad = (^data_in) != par_in;
    beat_ok    = !(PARITY_CHECK && parity_bad);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      base_addr  <= 4'h0;
      burst_mode <= 2'b00;
      long_burst <= 1'b0;
      beat_cnt   <= 2'd0;
      ready      <= 1'b0;
      add_2_mem  <= 4'h0;
      data_2_mem <= 32'h0;
      wr_en      <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      wr_en <= 1'b0;
      done  <= 1'b0;
      err   <= 1'b0;
      case (state)
        IDLE: begin
          if (en) begin
            if (cmd_ok) begin
              base_addr  <= local_address;
              burst_mode <= mode;
              long_burst <= (cmd == CMD_MEM_WRITE_INV);
              beat_cnt   <= 2'd0;
              busy       <= 1'b1;
              ready      <= 1'b1;
              state      <= DATA;
            end else begin
              err <= 1'b1;
            end
          end
        end
        DATA: begin
          if (ready && data_valid) begin
            // A parity-faulted beat is dropped but still advances the address sequence.
            if (beat_ok) begin
              wr_en      <= 1'b1;
              add_2_mem  <= beat_addr;
              data_2_mem <= data_in;
            end else begin
              err <= 1'b1;
            end
            beat_cnt <= beat_cnt + 2'd1;
            if (last_beat) begin
              ready <= 1'b0;
              done  <= 1'b1;
              state <= DONE;
            end
          end
        end
        DONE: begin
          busy     <= 1'b0;
          beat_cnt <= 2'd0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
